// File: rtl/fifo_nibble_packer.sv
// Drains a first-word-fall-through nibble FIFO and packs WORD_NIBBLES nibbles per word,
// presented on a valid/ready port with flush-to-partial support and an accepted-word counter.
module fifo_nibble_packer #(
  parameter int DATA_WIDTH   = 4,
  parameter int WORD_NIBBLES = 2,
  parameter int MSB_FIRST    = 0,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               fifo_empty,
  input  logic [DATA_WIDTH-1:0]              fifo_rdata,
  output logic                               fifo_rinc,
  input  logic                               flush,
  output logic [DATA_WIDTH*WORD_NIBBLES-1:0] out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_partial,
  output logic [CNT_WIDTH-1:0]               word_count
);

  localparam int OUT_W = DATA_WIDTH * WORD_NIBBLES;
  localparam int IDX_W = $clog2(WORD_NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_OUT  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [OUT_W-1:0]       shift_q, shift_d;
  logic [OUT_W-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_partial_q, out_partial_d;
  logic [CNT_WIDTH-1:0]   word_count_q, word_count_d;

  logic                   pop_s;
  logic [IDX_W-1:0]       slot_s;
  logic [IDX_W-1:0]       first_slot_s;
  logic [OUT_W-1:0]       shift_ins_s;

  function automatic logic [OUT_W-1:0] put_nibble(
    input logic [OUT_W-1:0]      word,
    input logic [IDX_W-1:0]      slot,
    input logic [DATA_WIDTH-1:0] nib
  );
    logic [OUT_W-1:0] r;
    r = word;
    for (int i = 0; i < WORD_NIBBLES; i++) begin
      if (IDX_W'(i) == slot) begin
        r[i*DATA_WIDTH +: DATA_WIDTH] = nib;
      end else begin
        r[i*DATA_WIDTH +: DATA_WIDTH] = word[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return r;
  endfunction

  // Pop whenever a nibble is available and there is room: in FILL, or in OUT on the accept edge.
  assign pop_s     = !rst && !fifo_empty && ((state_q == ST_FILL) || out_ready);
  assign fifo_rinc = pop_s;

  assign slot_s       = (MSB_FIRST != 0) ? (IDX_LAST - idx_q) : idx_q;
  assign first_slot_s = (MSB_FIRST != 0) ? IDX_LAST : {IDX_W{1'b0}};
  assign shift_ins_s  = put_nibble(shift_q, slot_s, fifo_rdata);

  // Next-state, packing and handshake logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_partial_d = out_partial_q;
    word_count_d  = word_count_q;

    case (state_q)
      ST_FILL: begin
        if (pop_s) begin
          if ((idx_q == IDX_LAST) || flush) begin
            // Word closes on this pop; partial only if slots remain unfilled.
            out_data_d    = shift_ins_s;
            out_valid_d   = 1'b1;
            out_partial_d = (idx_q != IDX_LAST);
            idx_d         = {IDX_W{1'b0}};
            shift_d       = {OUT_W{1'b0}};
            state_d       = ST_OUT;
          end else begin
            shift_d = shift_ins_s;
            idx_d   = idx_q + IDX_ONE;
          end
        end else if (flush && (idx_q != {IDX_W{1'b0}})) begin
          out_data_d    = shift_q;
          out_valid_d   = 1'b1;
          out_partial_d = 1'b1;
          idx_d         = {IDX_W{1'b0}};
          shift_d       = {OUT_W{1'b0}};
          state_d       = ST_OUT;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          word_count_d  = word_count_q + CNT_WIDTH'(1);
          out_valid_d   = 1'b0;
          out_partial_d = 1'b0;
          state_d       = ST_FILL;
          if (pop_s) begin
            shift_d = put_nibble({OUT_W{1'b0}}, first_slot_s, fifo_rdata);
            idx_d   = IDX_ONE;
          end else begin
            shift_d = {OUT_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d       = ST_FILL;
        idx_d         = {IDX_W{1'b0}};
        shift_d       = {OUT_W{1'b0}};
        out_valid_d   = 1'b0;
        out_partial_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FILL;
      idx_q         <= {IDX_W{1'b0}};
      shift_q       <= {OUT_W{1'b0}};
      out_data_q    <= {OUT_W{1'b0}};
      out_valid_q   <= 1'b0;
      out_partial_q <= 1'b0;
      word_count_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_partial_q <= out_partial_d;
      word_count_q  <= word_count_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_partial = out_partial_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Scoreboard bench for fifo_nibble_packer: FIFO model feeds nibbles, a monitor checks every accepted word.
module tb_fifo_nibble_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [3:0] fifo_rdata;
  logic       fifo_rinc;
  logic       flush;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_partial;
  logic [7:0] word_count;

  logic       m_empty;
  logic [3:0] m_rdata;
  logic       m_rinc;
  logic       m_flush;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_partial;
  logic [7:0] m_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       partial;
  } exp_t;
  exp_t sb[$];

  logic [3:0]  mem [0:2047];
  logic [31:0] rd_ptr = 32'd0;
  logic [31:0] wr_ptr = 32'd0;
  int          pop_cnt = 0;

  logic [3:0]  m_mem [0:3];
  logic [31:0] m_rd = 32'd0;
  logic [31:0] m_wr = 32'd0;

  logic [7:0]  exp_cnt = 8'd0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr[10:0]];
  assign m_empty    = (m_rd == m_wr);
  assign m_rdata    = m_mem[m_rd[1:0]];

  fifo_nibble_packer #(.DATA_WIDTH(4), .WORD_NIBBLES(2), .MSB_FIRST(0), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rinc(fifo_rinc), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_partial(out_partial), .word_count(word_count)
  );

  fifo_nibble_packer #(.DATA_WIDTH(4), .WORD_NIBBLES(2), .MSB_FIRST(1), .CNT_WIDTH(8)) u_dut_msb (
    .clk(clk), .rst(rst), .fifo_empty(m_empty), .fifo_rdata(m_rdata),
    .fifo_rinc(m_rinc), .flush(m_flush), .out_data(m_data), .out_valid(m_valid),
    .out_ready(m_ready), .out_partial(m_partial), .word_count(m_count)
  );

  // FIFO models: consume the head on each pop edge.
  always @(posedge clk) begin
    if (fifo_rinc) begin
      rd_ptr  <= rd_ptr + 32'd1;
      pop_cnt <= pop_cnt + 1;
    end
    if (m_rinc) m_rd <= m_rd + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted word against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 8'd0;
    end else if (out_valid && out_ready) begin
      check("word_count_at_xfer", {24'd0, word_count}, {24'd0, exp_cnt});
      exp_cnt = exp_cnt + 8'd1;
      if (sb.size() == 0) begin
        check("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e.data});
        check("out_partial", {31'd0, out_partial}, {31'd0, e.partial});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] n);
    mem[wr_ptr[10:0]] = n;
    wr_ptr = wr_ptr + 32'd1;
  endtask

  task automatic expect_word(input logic [7:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.partial = p;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (fifo_empty && !out_valid && sb.size() == 0) done = 1'b1;
    end
    check("idle_timeout", {31'd0, done}, 32'd1);
    tick();
  endtask

  initial begin
    int p0;
    bit seen;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; m_flush = 1'b0; m_ready = 1'b1;

    // Reset state, with data already waiting in the FIFO
    push(4'h3);
    tick(); tick();
    @(negedge clk);
    check("rst_rinc", {31'd0, fifo_rinc}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_partial", {31'd0, out_partial}, 32'd0);
    check("rst_count", {24'd0, word_count}, 32'd0);
    tick();
    rst = 1'b0;

    // Basic pack, LSB-first and MSB-first
    p0 = pop_cnt;
    push(4'hA);
    expect_word(8'hA3, 1'b0);
    m_mem[0] = 4'h3; m_mem[1] = 4'hA; m_wr = 32'd2;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (m_valid) begin
        seen = 1'b1;
        check("msb_first_data", {24'd0, m_data}, 32'h3A);
        check("msb_first_partial", {31'd0, m_partial}, 32'd0);
      end
    end
    check("msb_first_seen", {31'd0, seen}, 32'd1);
    wait_idle(20);
    check("basic_pops", pop_cnt - p0, 32'd2);
    check("basic_count", {24'd0, word_count}, 32'd1);

    // Backpressure
    out_ready = 1'b0;
    push(4'h1); push(4'h2); push(4'h5); push(4'h6);
    expect_word(8'h21, 1'b0);
    expect_word(8'h65, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("bp_valid_seen", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_data", {24'd0, out_data}, 32'h21);
      check("bp_no_pop", {31'd0, fifo_rinc}, 32'd0);
    end
    tick();
    out_ready = 1'b1;
    wait_idle(20);
    check("bp_count", {24'd0, word_count}, 32'd3);

    // Flush of a partial word
    push(4'h7);
    expect_word(8'h07, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle(20);
    // Flush with nothing collected is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_empty_no_valid", {31'd0, out_valid}, 32'd0);
    end
    // Flush coincident with the completing pop
    tick();
    push(4'hC);
    expect_word(8'h9C, 1'b0);
    tick();
    push(4'h9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle(20);
    check("flush_count", {24'd0, word_count}, 32'd5);

    // Empty FIFO mid-word
    push(4'h4);
    expect_word(8'hE4, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("empty_no_pop", {31'd0, fifo_rinc}, 32'd0);
      check("empty_no_valid", {31'd0, out_valid}, 32'd0);
    end
    tick();
    push(4'hE);
    wait_idle(20);

    // Reset mid-word discards the popped nibble
    push(4'h8);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_count", {24'd0, word_count}, 32'd0);
    tick();
    rst = 1'b0;
    push(4'h1); push(4'h2);
    expect_word(8'h21, 1'b0);
    wait_idle(20);
    check("rst_mid_count_after", {24'd0, word_count}, 32'd1);

    // 256 words: counter wraps to zero
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int w = 0; w < 256; w++) begin
      logic [7:0] b;
      b = 8'(w);
      push(b[3:0]);
      push(b[7:4]);
      expect_word(b, 1'b0);
    end
    wait_idle(1200);
    check("wrap_count", {24'd0, word_count}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
